// File: rtl/mem_pkg.sv
// mem_pkg: constants shared by the RAM path (arbiter modes,
// arbiter FSM states, default RAM widths also used by ram).
package mem_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: per-port request bundle of the RAM arbiter.
// master = requester side (req/we/addr/wdata out), slave = arbiter.
interface ram_arbiter_if
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] we;
  logic [NUM_PORTS-1:0] ready;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/arb_picker.sv
// arb_picker: combinational grant selection over an eligible mask.
// In: eligible, last, rr (1 = round-robin). Out: grant, valid.
module arb_picker
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [IW-1:0] last,
  input  logic rr,
  output logic [IW-1:0] grant,
  output logic valid
);

  function automatic int slot(int k, int base, logic mode);
    return mode ? (base + k) % NUM_PORTS : k - 1;
  endfunction

  // Scan from the far end so the last hit is the
  // first port in scan order.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (eligible[IW'(slot(k, int'(last), rr))]) begin
        grant = IW'(slot(k, int'(last), rr));
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises N requester ports onto one sync RAM.
// Ports: ram_clk, rst (async low), bus (slave), busy, mem_* to ram.
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ARB_MODE = ARB_FIXED,
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic ram_clk,
  input  logic rst,
  ram_arbiter_if.slave bus,
  output logic busy,
  output logic mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_t state;
  logic [IW-1:0] gnt;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic pick_v;
  logic op_we;
  logic [NUM_PORTS-1:0] ready_q;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q;

  // A port is masked in its ready cycle so one
  // held request cannot complete twice.
  assign eligible = bus.req & ~ready_q;
  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

  arb_picker #(
    .NUM_PORTS(NUM_PORTS)
  ) u_pick (
    .eligible(eligible),
    .last(last),
    .rr(ARB_MODE == ARB_RR),
    .grant(pick),
    .valid(pick_v)
  );

  always_ff @(posedge ram_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt <= '0;
      last <= IW'(NUM_PORTS - 1);
      op_we <= 1'b0;
      ready_q <= '0;
      rdata_q <= '0;
      busy <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      ready_q <= '0;
      unique case (state)
        IDLE: begin
          if (pick_v) begin
            gnt <= pick;
            op_we <= bus.we[pick];
            mem_we <= bus.we[pick];
            mem_addr <= bus.addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata <= bus.wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            busy <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (!op_we) begin
            rdata_q[int'(gnt)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
          end
          ready_q[gnt] <= 1'b1;
          if (ARB_MODE == ARB_RR) begin
            last <= gnt;
          end
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Parametrised N-port arbiter in front of the single-port synchronous `ram`, replacing the hard-wired three-requester prioritiser. Each pipeline stage (fetch/decode, RAM read, RAM save, and future stages) gets an identical req/ready port. The arbiter serialises accesses onto the RAM with either fixed-priority or round-robin selection, and returns read data per port. It sits between the CPU stages and `ram`, and drives `ram`'s write_enable, address and data_in directly.

## Interface
- NUM_PORTS, 3: number of requester ports, 1..8.
- ADDR_WIDTH, 16: RAM address width.
- DATA_WIDTH, 8: RAM data width.
- ARB_MODE, 0: 0 = fixed priority (port 0 highest); 1 = round-robin.

- ram_clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_PORTS  per-port access request, level, held until ready.
- we  in  NUM_PORTS  per-port 1 = write, 0 = read; valid while req is high.
- addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at slice i.
- wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- ready  out  NUM_PORTS  one-cycle completion pulse per port.
- rdata  out  NUM_PORTS*DATA_WIDTH  per-port read data, held until that port's next read completes.
- busy  out  1  high while an access is in flight (FSM not IDLE).
- mem_we  out  1  to ram write_enable.
- mem_addr  out  ADDR_WIDTH  to ram address.
- mem_wdata  out  DATA_WIDTH  to ram data_in.
- mem_rdata  in  DATA_WIDTH  from ram data_out (registered inside ram, 1-cycle latency).

## Operation
- The FSM has three states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - eligible = req & ~ready.
  - If eligible is nonzero, select grant index g, register port g's we, addr and wdata onto mem_*, latch g, and go to ISSUE.
- ISSUE:
  - mem_* stable; ram samples at the end of this cycle.
  - Go to CAPTURE, and drive mem_we to 0 on that transition.
- CAPTURE:
  - For a read, rdata[g] <= mem_rdata.
  - ready[g] <= 1 for one cycle, for both reads and writes.
  - If ARB_MODE=1, last <= g.
  - Go to IDLE.
- Fixed priority: g is the lowest-index eligible port.
- Round-robin: g is the first eligible port scanning last+1, last+2, … modulo NUM_PORTS.
- Requester protocol: drop req, or present a new request, in the cycle after ready is seen. A port's req is masked while its ready is high, so a single request never completes twice.
- req dropped mid-access (a protocol violation): the access still completes and ready still pulses.
- Writes never modify rdata.
- NUM_PORTS=1: both modes are identical.

## Timing
- Request sampled in IDLE at cycle 0 → ISSUE cycle 1 → CAPTURE cycle 2 → ready high in cycle 3 (registered).
- The FSM is back in IDLE in cycle 3 and may grant another port that same cycle.
- Peak throughput: one access per 3 cycles.
- Read-after-write to the same address from any ports returns the new data, because accesses are strictly serialised.
- Reset (rst low, asynchronous, any state):
  - state = IDLE.
  - ready = 0, rdata = 0, busy = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - last = NUM_PORTS-1, so port 0 is first after reset in round-robin.
- An in-flight access aborted by reset produces no ready. A write aborted before its ISSUE edge does not reach the RAM.
- Simultaneous requests:
  - Exactly one grant per IDLE cycle.
  - Ungranted ports wait with no loss of request.
  - Round-robin wait is bounded by NUM_PORTS-1 accesses.

## Structure
- Shared package `mem_pkg`:
  - ARB_FIXED=0 and ARB_RR=1 constants.
  - FSM state encoding: IDLE, ISSUE, CAPTURE.
  - Default ADDR_WIDTH/DATA_WIDTH, shared with `ram`.
- Sub-module `arb_picker`:
  - Combinational.
  - Inputs: eligible mask, last, mode.
  - Outputs: grant index and a valid flag.
  - Verified standalone.
- The FSM and per-port rdata registers stay in ram_arbiter.

## Test plan
- Fixed mode, NUM_PORTS=3, ram preloaded with mem[5]=8'hA5:
  - Ports 0 (write addr 7, data 8'h3C), 1 (read addr 5) and 2 (read addr 7) request in the same cycle.
  - Required: grant order 0,1,2; ready pulses at cycles 3, 6 and 9; rdata1=8'hA5, rdata2=8'h3C.
- Round-robin mode, all three ports hold req continuously:
  - Required: grant sequence 0,1,2,0,1,2; no port waits more than 2 accesses.
- Single-read latency:
  - Port 1 reads address 16'hFFFF.
  - Required: mem_addr=16'hFFFF in cycle 1; ready[1] in cycle 3 only; busy high in cycles 1–2.
- Reset mid-access:
  - Drop rst during ISSUE of a write of 8'h55 to address 3.
  - Required: all outputs return to their reset values; no ready pulse; after release, port 0 is granted first.
- Back-to-back from one port:
  - Port 2 re-raises req in the cycle after ready.
  - Required: next grant to port 2 with ready exactly 3 cycles later.
  - Holding req high through the ready cycle must not produce a duplicate access.
